// File: rtl/fft_pkg.sv
// Shared constants, types and fixed-point helpers for the 8-point radix-2 DIT FFT.
package fft_pkg;

    localparam int DW   = 32;
    localparam int FW   = 16;
    localparam int NPT  = 8;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic [1:0] {
        TW_0 = 2'd0,
        TW_1 = 2'd1,
        TW_2 = 2'd2,
        TW_3 = 2'd3
    } tw_sel_t;

    localparam sample_t W0R = 32'sh0001_0000;
    localparam sample_t W0I = 32'sh0000_0000;
    localparam sample_t W1R = 32'sh0000_B505;
    localparam sample_t W1I = 32'shFFFF_4AFB;
    localparam sample_t W2R = 32'sh0000_0000;
    localparam sample_t W2I = 32'shFFFF_0000;
    localparam sample_t W3R = 32'shFFFF_4AFB;
    localparam sample_t W3I = 32'shFFFF_4AFB;

    // Q16.16 multiply: full 64-bit signed product, keep bits [47:16] (floor rounding).
    function automatic sample_t q_mul(input sample_t a, input sample_t b);
        logic signed [2*DW-1:0] ae;
        logic signed [2*DW-1:0] be;
        logic signed [2*DW-1:0] p;
        ae = a;
        be = b;
        p  = ae * be;
        return p[FW+DW-1:FW];
    endfunction

    function automatic int brev3(input int n);
        return {29'd0, n[0], n[1], n[2]};
    endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 complex butterfly (a + W*b, a - W*b); W0/W2 need no multiplier.
// FFT_STAGE_SCALE_EN: halve both outputs (arithmetic shift of the 33-bit sum).
module fft_bfly
    import fft_pkg::*;
(
    input  sample_t ar,
    input  sample_t ai,
    input  sample_t br,
    input  sample_t bi,
    input  tw_sel_t tw,
    output sample_t pr,
    output sample_t pi,
    output sample_t mr,
    output sample_t mi
);

    sample_t wr_s;
    sample_t wi_s;
    sample_t mre_s;
    sample_t mim_s;
    sample_t tr_s;
    sample_t ti_s;
    logic signed [DW:0] sr_s;
    logic signed [DW:0] si_s;
    logic signed [DW:0] dr_s;
    logic signed [DW:0] di_s;

    // Multiplier twiddle: only W1 and W3 reach the multiplier path.
    always_comb begin
        wr_s = W1R;
        wi_s = W1I;
        if (tw == TW_3) begin
            wr_s = W3R;
            wi_s = W3I;
        end else begin
            wr_s = W1R;
            wi_s = W1I;
        end
    end

    assign mre_s = q_mul(br, wr_s) - q_mul(bi, wi_s);
    assign mim_s = q_mul(br, wi_s) + q_mul(bi, wr_s);

    // W*b: pass-through for W0, multiply by -j for W2, full complex product otherwise.
    always_comb begin
        tr_s = br;
        ti_s = bi;
        case (tw)
            TW_0: begin
                tr_s = br;
                ti_s = bi;
            end
            TW_2: begin
                tr_s = bi;
                ti_s = -br;
            end
            TW_1, TW_3: begin
                tr_s = mre_s;
                ti_s = mim_s;
            end
            default: begin
                tr_s = br;
                ti_s = bi;
            end
        endcase
    end

    assign sr_s = {ar[DW-1], ar} + {tr_s[DW-1], tr_s};
    assign si_s = {ai[DW-1], ai} + {ti_s[DW-1], ti_s};
    assign dr_s = {ar[DW-1], ar} - {tr_s[DW-1], tr_s};
    assign di_s = {ai[DW-1], ai} - {ti_s[DW-1], ti_s};

`ifdef FFT_STAGE_SCALE_EN
    assign pr = sr_s[DW:1];
    assign pi = si_s[DW:1];
    assign mr = dr_s[DW:1];
    assign mi = di_s[DW:1];
`else
    assign pr = sr_s[DW-1:0];
    assign pi = si_s[DW-1:0];
    assign mr = dr_s[DW-1:0];
    assign mi = di_s[DW-1:0];
`endif

endmodule

// File: rtl/fft_core.sv
// 8-point radix-2 DIT FFT, three registered butterfly stages, one vector per cycle.
// Optional macro FFT_STAGE_SCALE_EN scales each stage by 1/2 (result = DFT/8).
module fft_core
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] x0r, input logic [DW-1:0] x1r, input logic [DW-1:0] x2r, input logic [DW-1:0] x3r,
    input  logic [DW-1:0] x4r, input logic [DW-1:0] x5r, input logic [DW-1:0] x6r, input logic [DW-1:0] x7r,
    input  logic [DW-1:0] x0i, input logic [DW-1:0] x1i, input logic [DW-1:0] x2i, input logic [DW-1:0] x3i,
    input  logic [DW-1:0] x4i, input logic [DW-1:0] x5i, input logic [DW-1:0] x6i, input logic [DW-1:0] x7i,
    output logic [DW-1:0] X0r, output logic [DW-1:0] X1r, output logic [DW-1:0] X2r, output logic [DW-1:0] X3r,
    output logic [DW-1:0] X4r, output logic [DW-1:0] X5r, output logic [DW-1:0] X6r, output logic [DW-1:0] X7r,
    output logic [DW-1:0] X0i, output logic [DW-1:0] X1i, output logic [DW-1:0] X2i, output logic [DW-1:0] X3i,
    output logic [DW-1:0] X4i, output logic [DW-1:0] X5i, output logic [DW-1:0] X6i, output logic [DW-1:0] X7i
);

    sample_t x_re_s [NPT];
    sample_t x_im_s [NPT];
    sample_t s1_re_s [NPT];
    sample_t s1_im_s [NPT];
    sample_t s2_re_s [NPT];
    sample_t s2_im_s [NPT];
    sample_t s3_re_s [NPT];
    sample_t s3_im_s [NPT];
    sample_t s1_re_r [NPT];
    sample_t s1_im_r [NPT];
    sample_t s2_re_r [NPT];
    sample_t s2_im_r [NPT];
    sample_t out_re_r [NPT];
    sample_t out_im_r [NPT];

    assign x_re_s[0] = x0r; assign x_re_s[1] = x1r; assign x_re_s[2] = x2r; assign x_re_s[3] = x3r;
    assign x_re_s[4] = x4r; assign x_re_s[5] = x5r; assign x_re_s[6] = x6r; assign x_re_s[7] = x7r;
    assign x_im_s[0] = x0i; assign x_im_s[1] = x1i; assign x_im_s[2] = x2i; assign x_im_s[3] = x3i;
    assign x_im_s[4] = x4i; assign x_im_s[5] = x5i; assign x_im_s[6] = x6i; assign x_im_s[7] = x7i;

    // Stage 1 reads the inputs in bit-reversed order; all twiddles are W0.
    for (genvar b = 0; b < NPT/2; b++) begin : g_s1
        localparam int TA = brev3(2*b);
        localparam int TB = brev3(2*b + 1);
        fft_bfly u_bfly (
            .ar(x_re_s[TA]), .ai(x_im_s[TA]), .br(x_re_s[TB]), .bi(x_im_s[TB]), .tw(TW_0),
            .pr(s1_re_s[2*b]), .pi(s1_im_s[2*b]), .mr(s1_re_s[2*b+1]), .mi(s1_im_s[2*b+1])
        );
    end

    for (genvar b = 0; b < NPT/2; b++) begin : g_s2
        localparam int      TOP = 4*(b/2) + (b%2);
        localparam int      BOT = TOP + 2;
        localparam tw_sel_t TWS = ((b % 2) == 1) ? TW_2 : TW_0;
        fft_bfly u_bfly (
            .ar(s1_re_r[TOP]), .ai(s1_im_r[TOP]), .br(s1_re_r[BOT]), .bi(s1_im_r[BOT]), .tw(TWS),
            .pr(s2_re_s[TOP]), .pi(s2_im_s[TOP]), .mr(s2_re_s[BOT]), .mi(s2_im_s[BOT])
        );
    end

    // Final stage lands directly in natural order: X[b] and X[b+4].
    for (genvar b = 0; b < NPT/2; b++) begin : g_s3
        localparam logic [1:0] TWB = 2'(b);
        fft_bfly u_bfly (
            .ar(s2_re_r[b]), .ai(s2_im_r[b]), .br(s2_re_r[b+4]), .bi(s2_im_r[b+4]), .tw(tw_sel_t'(TWB)),
            .pr(s3_re_s[b]), .pi(s3_im_s[b]), .mr(s3_re_s[b+4]), .mi(s3_im_s[b+4])
        );
    end

    // Pipeline registers for the three stages; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NPT; k++) begin
                s1_re_r[k]  <= 32'sd0;
                s1_im_r[k]  <= 32'sd0;
                s2_re_r[k]  <= 32'sd0;
                s2_im_r[k]  <= 32'sd0;
                out_re_r[k] <= 32'sd0;
                out_im_r[k] <= 32'sd0;
            end
        end else begin
            s1_re_r  <= s1_re_s;
            s1_im_r  <= s1_im_s;
            s2_re_r  <= s2_re_s;
            s2_im_r  <= s2_im_s;
            out_re_r <= s3_re_s;
            out_im_r <= s3_im_s;
        end
    end

    assign X0r = out_re_r[0]; assign X1r = out_re_r[1]; assign X2r = out_re_r[2]; assign X3r = out_re_r[3];
    assign X4r = out_re_r[4]; assign X5r = out_re_r[5]; assign X6r = out_re_r[6]; assign X7r = out_re_r[7];
    assign X0i = out_im_r[0]; assign X1i = out_im_r[1]; assign X2i = out_im_r[2]; assign X3i = out_im_r[3];
    assign X4i = out_im_r[4]; assign X5i = out_im_r[5]; assign X6i = out_im_r[6]; assign X7i = out_im_r[7];

endmodule

// File: tb/tb_fft_core.sv
// Scoreboard bench for fft_core: the driver queues hand-computed bins, a negedge monitor checks them.
module tb_fft_core;

    localparam logic [31:0] ONE = 32'h0001_0000;
    localparam logic [31:0] NEG = 32'hFFFF_0000;
    localparam logic [31:0] CP  = 32'h0000_B505;
    localparam logic [31:0] CN  = 32'hFFFF_4AFB;

    typedef struct {
        int          due;
        string       name;
        logic [7:0]  mask;
        logic [31:0] er [8];
        logic [31:0] ei [8];
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] xr [8];
    logic [31:0] xi [8];
    logic [31:0] yr [8];
    logic [31:0] yi [8];
    logic [31:0] er_v [8];
    logic [31:0] ei_v [8];
    exp_t        sbq [$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fft_core dut (
        .clk(clk), .rst_n(rst_n),
        .x0r(xr[0]), .x1r(xr[1]), .x2r(xr[2]), .x3r(xr[3]), .x4r(xr[4]), .x5r(xr[5]), .x6r(xr[6]), .x7r(xr[7]),
        .x0i(xi[0]), .x1i(xi[1]), .x2i(xi[2]), .x3i(xi[3]), .x4i(xi[4]), .x5i(xi[5]), .x6i(xi[6]), .x7i(xi[7]),
        .X0r(yr[0]), .X1r(yr[1]), .X2r(yr[2]), .X3r(yr[3]), .X4r(yr[4]), .X5r(yr[5]), .X6r(yr[6]), .X7r(yr[7]),
        .X0i(yi[0]), .X1i(yi[1]), .X2i(yi[2]), .X3i(yi[3]), .X4i(yi[4]), .X5i(yi[5]), .X6i(yi[6]), .X7i(yi[7])
    );

    task automatic clr_in();
        for (int k = 0; k < 8; k++) begin
            xr[k] = 32'h0;
            xi[k] = 32'h0;
        end
    endtask

    task automatic set_exp(input logic [31:0] r, input logic [31:0] i);
        for (int k = 0; k < 8; k++) begin
            er_v[k] = r;
            ei_v[k] = i;
        end
    endtask

    task automatic push(input string nm, input logic [7:0] m, input int lat);
        exp_t e;
        e.due  = cyc + lat;
        e.name = nm;
        e.mask = m;
        e.er   = er_v;
        e.ei   = ei_v;
        sbq.push_back(e);
    endtask

    task automatic exp_shifted();
        er_v[0] = ONE; ei_v[0] = 32'h0;
        er_v[1] = CP;  ei_v[1] = CN;
        er_v[2] = 32'h0; ei_v[2] = NEG;
        er_v[3] = CN;  ei_v[3] = CN;
        er_v[4] = NEG; ei_v[4] = 32'h0;
        er_v[5] = CN;  ei_v[5] = CP;
        er_v[6] = 32'h0; ei_v[6] = ONE;
        er_v[7] = CP;  ei_v[7] = CP;
    endtask

    task automatic check_zero(input string nm);
        logic bad;
        bad = 1'b0;
        n_tests++;
        for (int k = 0; k < 8; k++) begin
            if (yr[k] !== 32'h0 || yi[k] !== 32'h0) begin
                bad = 1'b1;
                $display("FAIL %s bin%0d: got (%h,%h) expected (00000000,00000000)", nm, k, yr[k], yi[k]);
            end
        end
        if (bad) n_fail++;
    endtask

    // Monitor: compare whichever queued result is due on this cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            logic bad;
            bad = 1'b0;
            mon_e = sbq.pop_front();
            n_tests++;
            for (int k = 0; k < 8; k++) begin
                if (mon_e.mask[k] && (yr[k] !== mon_e.er[k] || yi[k] !== mon_e.ei[k])) begin
                    bad = 1'b1;
                    $display("FAIL %s bin%0d: got (%h,%h) expected (%h,%h)",
                             mon_e.name, k, yr[k], yi[k], mon_e.er[k], mon_e.ei[k]);
                end
            end
            if (bad) n_fail++;
        end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
            mon_e = sbq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: result due at cycle %0d never checked (now %0d)", mon_e.name, mon_e.due, cyc);
        end
    end

    initial begin
        rst_n = 1'b0;
        clr_in();
        set_exp(32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;

        @(negedge clk); clr_in(); xr[0] = ONE;
        set_exp(ONE, 32'h0); push("impulse", 8'hFF, 3);

        @(negedge clk); clr_in(); xr[1] = ONE;
        exp_shifted(); push("shifted_impulse", 8'hFF, 3);

        @(negedge clk); clr_in(); xr[4] = ONE;
        set_exp(ONE, 32'h0);
        er_v[1] = NEG; er_v[3] = NEG; er_v[5] = NEG; er_v[7] = NEG;
        push("impulse_x4", 8'hFF, 3);

        @(negedge clk); clr_in(); xi[0] = ONE;
        set_exp(32'h0, ONE); push("imag_impulse", 8'hFF, 3);

        @(negedge clk); clr_in();
        for (int n = 0; n < 8; n++) begin
            if (n == 2 || n == 5) begin
                xr[n] = 32'h0000_51EB; xi[n] = 32'h0000_E147;
            end else if (n % 3 == 0) begin
                xr[n] = 32'hFFFF_CCCD; xi[n] = 32'h0001_9999;
            end else begin
                xr[n] = 32'h0001_3333; xi[n] = 32'h0001_9999;
            end
        end
        set_exp(32'h0, 32'h0);
        er_v[0] = 32'h0003_A3D6; ei_v[0] = 32'h000B_5C24;
        er_v[2] = 32'h0000_28F6; ei_v[2] = 32'h0000_3334;
        er_v[4] = 32'hFFFE_999A; ei_v[4] = 32'h0000_0000;
        er_v[6] = 32'h0001_999A; ei_v[6] = 32'h0001_3D70;
        push("mixed", 8'h55, 3);

        @(negedge clk); clr_in();
        for (int n = 0; n < 8; n++) xr[n] = (n % 2 == 0) ? ONE : NEG;
        set_exp(32'h0, 32'h0); er_v[4] = 32'h0008_0000; push("alternating", 8'hFF, 3);

        @(negedge clk); clr_in(); xr[0] = ONE;
        set_exp(ONE, 32'h0); push("b2b_impulse", 8'hFF, 3);

        @(negedge clk); clr_in();
        for (int n = 0; n < 8; n++) xr[n] = ONE;
        set_exp(32'h0, 32'h0); er_v[0] = 32'h0008_0000; push("b2b_dc", 8'hFF, 3);

        @(negedge clk); clr_in();
        repeat (4) @(negedge clk);

        // Reset mid-stream: two vectors in flight, then drop rst_n between edges.
        clr_in(); xr[0] = ONE;
        set_exp(ONE, 32'h0); push("flushed_impulse", 8'hFF, 3);
        @(negedge clk);
        for (int n = 0; n < 8; n++) xr[n] = ONE;
        #2 rst_n = 1'b0;
        #1 check_zero("reset_async");
        sbq.delete();
        @(negedge clk);
        check_zero("reset_hold");
        clr_in(); xr[1] = ONE;
        rst_n = 1'b1;
        check_zero("post_release");
        set_exp(32'h0, 32'h0);
        push("latency_zero_1", 8'hFF, 1);
        push("latency_zero_2", 8'hFF, 2);
        exp_shifted(); push("post_reset_result", 8'hFF, 3);

        repeat (5) @(negedge clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results left unchecked, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
